// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encoding for the common data bus arbiter.
// Entry-width helpers keep the FIFO packing in one place.
package cdb_arbiter_pkg;

    localparam int CDB_DAT_W   = 32;
    localparam int CDB_ROB_BIT = 4;
    localparam int CDB_DEPTH   = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

    function automatic int alu_ent_w(input int dw, input int rb);
        return rb + 2 * dw + 1;
    endfunction

    function automatic int lsb_ent_w(input int dw, input int rb);
        return rb + dw;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result FIFO with flush and same-cycle bypass support.
// A pop of an empty FIFO consumes the incoming push without storing it.
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             wr;
    logic             rd;

    assign empty = (count == '0);
    assign full  = (count == CAP);
    assign wr    = push && !(empty && pop);
    assign rd    = pop && !empty;
    assign rdata = mem[rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (en) begin
            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (wr) wp <= wp + 1'b1;
                if (rd) rp <= rp + 1'b1;
                count <= count + CW'(wr) - CW'(rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && !flush && wr) mem[wp] <= wdata;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of the registered CDB between ALU and LSB results.
// Mispredict flush drops everything queued and re-arms ALU priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DAT_W   = CDB_DAT_W,
    parameter int ROB_BIT = CDB_ROB_BIT,
    parameter int DEPTH   = CDB_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               alu_en_i,
    input  logic [ROB_BIT-1:0] alu_q_i,
    input  logic [DAT_W-1:0]   alu_v_i,
    input  logic               alu_cbr_i,
    input  logic [DAT_W-1:0]   alu_cbt_i,
    output logic               alu_rdy_o,
    input  logic               lsb_en_i,
    input  logic [ROB_BIT-1:0] lsb_q_i,
    input  logic [DAT_W-1:0]   lsb_v_i,
    output logic               lsb_rdy_o,
    input  logic               br_flag,
    output logic               cdb_en_o,
    output logic [ROB_BIT-1:0] cdb_q_o,
    output logic [DAT_W-1:0]   cdb_v_o,
    output logic               cdb_cbr_o,
    output logic [DAT_W-1:0]   cdb_cbt_o,
    output logic               cdb_src_o
);

    localparam int AEW = alu_ent_w(DAT_W, ROB_BIT);
    localparam int LEW = lsb_ent_w(DAT_W, ROB_BIT);
    localparam int CW  = $clog2(DEPTH) + 1;

    logic            live;
    logic            alu_push, lsb_push;
    logic            alu_avail, lsb_avail;
    logic            gnt_alu, gnt_lsb;
    logic            alu_full, lsb_full;
    logic            alu_empty, lsb_empty;
    logic [CW-1:0]   alu_cnt, lsb_cnt;
    logic [AEW-1:0]  alu_wd, alu_rd, alu_head;
    logic [LEW-1:0]  lsb_wd, lsb_rd, lsb_head;
    cdb_src_e        rr;

    logic [ROB_BIT-1:0] ah_q, lh_q;
    logic [DAT_W-1:0]   ah_v, ah_cbt, lh_v;
    logic               ah_cbr;

    assign live      = en && !br_flag;
    assign alu_rdy_o = !alu_full;
    assign lsb_rdy_o = !lsb_full;
    assign alu_push  = live && alu_en_i && alu_rdy_o;
    assign lsb_push  = live && lsb_en_i && lsb_rdy_o;

    assign alu_wd = {alu_q_i, alu_v_i, alu_cbr_i, alu_cbt_i};
    assign lsb_wd = {lsb_q_i, lsb_v_i};

    // Empty FIFO forwards the incoming entry so it can win this cycle.
    assign alu_head  = alu_empty ? alu_wd : alu_rd;
    assign lsb_head  = lsb_empty ? lsb_wd : lsb_rd;
    assign alu_avail = (alu_cnt != '0) || alu_push;
    assign lsb_avail = (lsb_cnt != '0) || lsb_push;

    assign {ah_q, ah_v, ah_cbr, ah_cbt} = alu_head;
    assign {lh_q, lh_v}                 = lsb_head;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsb = 1'b0;
        if (live) begin
            if (alu_avail && lsb_avail) begin
                gnt_alu = (rr == SRC_ALU);
                gnt_lsb = (rr == SRC_LSB);
            end else begin
                gnt_alu = alu_avail;
                gnt_lsb = lsb_avail;
            end
        end
    end

    cdb_fifo #(.WIDTH(AEW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .push  (alu_push),
        .pop   (gnt_alu),
        .flush (br_flag),
        .wdata (alu_wd),
        .rdata (alu_rd),
        .count (alu_cnt),
        .full  (alu_full),
        .empty (alu_empty)
    );

    cdb_fifo #(.WIDTH(LEW), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .push  (lsb_push),
        .pop   (gnt_lsb),
        .flush (br_flag),
        .wdata (lsb_wd),
        .rdata (lsb_rd),
        .count (lsb_cnt),
        .full  (lsb_full),
        .empty (lsb_empty)
    );

    // rr names the source that wins the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr        <= SRC_ALU;
            cdb_en_o  <= 1'b0;
            cdb_q_o   <= '0;
            cdb_v_o   <= '0;
            cdb_cbr_o <= 1'b0;
            cdb_cbt_o <= '0;
            cdb_src_o <= SRC_ALU;
        end else if (en) begin
            if (br_flag) begin
                rr       <= SRC_ALU;
                cdb_en_o <= 1'b0;
            end else if (gnt_alu) begin
                rr        <= SRC_LSB;
                cdb_en_o  <= 1'b1;
                cdb_q_o   <= ah_q;
                cdb_v_o   <= ah_v;
                cdb_cbr_o <= ah_cbr;
                cdb_cbt_o <= ah_cbt;
                cdb_src_o <= SRC_ALU;
            end else if (gnt_lsb) begin
                rr        <= SRC_ALU;
                cdb_en_o  <= 1'b1;
                cdb_q_o   <= lh_q;
                cdb_v_o   <= lh_v;
                cdb_cbr_o <= 1'b0;
                cdb_cbt_o <= '0;
                cdb_src_o <= SRC_LSB;
            end else begin
                cdb_en_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, bypass, alternation,
// fill/drain, flush, freeze and async reset with hand-derived results.
module tb_cdb_arbiter;

    localparam int DW = 32;
    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          alu_en_i = 1'b0;
    logic [RB-1:0] alu_q_i = '0;
    logic [DW-1:0] alu_v_i = '0;
    logic          alu_cbr_i = 1'b0;
    logic [DW-1:0] alu_cbt_i = '0;
    logic          alu_rdy_o;
    logic          lsb_en_i = 1'b0;
    logic [RB-1:0] lsb_q_i = '0;
    logic [DW-1:0] lsb_v_i = '0;
    logic          lsb_rdy_o;
    logic          br_flag = 1'b0;
    logic          cdb_en_o;
    logic [RB-1:0] cdb_q_o;
    logic [DW-1:0] cdb_v_o;
    logic          cdb_cbr_o;
    logic [DW-1:0] cdb_cbt_o;
    logic          cdb_src_o;

    int tests = 0;
    int fails = 0;

    // Producer schedule and expected ready flags for the streaming run
    int a_push [12] = '{1,1,1,1,0,1,0,1,0,0,0,0};
    int l_push [12] = '{1,1,1,0,1,0,1,0,1,0,0,0};
    int a_rdy  [12] = '{1,1,1,1,0,1,0,1,0,1,1,1};
    int l_rdy  [12] = '{1,1,1,0,1,0,1,0,1,0,1,1};

    always #5 clk = ~clk;

    cdb_arbiter #(.DAT_W(DW), .ROB_BIT(RB), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .alu_en_i  (alu_en_i),
        .alu_q_i   (alu_q_i),
        .alu_v_i   (alu_v_i),
        .alu_cbr_i (alu_cbr_i),
        .alu_cbt_i (alu_cbt_i),
        .alu_rdy_o (alu_rdy_o),
        .lsb_en_i  (lsb_en_i),
        .lsb_q_i   (lsb_q_i),
        .lsb_v_i   (lsb_v_i),
        .lsb_rdy_o (lsb_rdy_o),
        .br_flag   (br_flag),
        .cdb_en_o  (cdb_en_o),
        .cdb_q_o   (cdb_q_o),
        .cdb_v_o   (cdb_v_o),
        .cdb_cbr_o (cdb_cbr_o),
        .cdb_cbt_o (cdb_cbt_o),
        .cdb_src_o (cdb_src_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input logic e,
                           input int q, input int v, input logic cbr,
                           input int cbt, input logic src);
        chk({tag, ".en"}, 64'(cdb_en_o), 64'(e));
        chk({tag, ".q"}, 64'(cdb_q_o), 64'(q));
        chk({tag, ".v"}, 64'(cdb_v_o), 64'(v));
        chk({tag, ".cbr"}, 64'(cdb_cbr_o), 64'(cbr));
        chk({tag, ".cbt"}, 64'(cdb_cbt_o), 64'(cbt));
        chk({tag, ".src"}, 64'(cdb_src_o), 64'(src));
    endtask

    task automatic idle();
        en        = 1'b1;
        br_flag   = 1'b0;
        alu_en_i  = 1'b0;
        alu_q_i   = '0;
        alu_v_i   = '0;
        alu_cbr_i = 1'b0;
        alu_cbt_i = '0;
        lsb_en_i  = 1'b0;
        lsb_q_i   = '0;
        lsb_v_i   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_alu(input int q, input int v, input logic cbr,
                            input int cbt);
        alu_en_i  = 1'b1;
        alu_q_i   = RB'(q);
        alu_v_i   = DW'(v);
        alu_cbr_i = cbr;
        alu_cbt_i = DW'(cbt);
    endtask

    task automatic push_lsb(input int q, input int v);
        lsb_en_i = 1'b1;
        lsb_q_i  = RB'(q);
        lsb_v_i  = DW'(v);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // A_i: q=i v=A0+i cbr=i[0] cbt=200+i ; L_i: q=8+i v=B0+i
    task automatic stream(input int n);
        int ai = 0;
        int li = 0;
        for (int c = 0; c < n; c++) begin
            idle();
            chk($sformatf("strm.c%0d.alu_rdy", c), 64'(alu_rdy_o),
                64'(a_rdy[c]));
            chk($sformatf("strm.c%0d.lsb_rdy", c), 64'(lsb_rdy_o),
                64'(l_rdy[c]));
            if (a_push[c] != 0) begin
                push_alu(ai, 'hA0 + ai, ai[0], 'h200 + ai);
                ai++;
            end
            if (l_push[c] != 0) begin
                push_lsb(8 + li, 'hB0 + li);
                li++;
            end
            step();
            if (c % 2 == 0)
                chk_cdb($sformatf("strm.c%0d", c), 1'b1, c / 2,
                        'hA0 + c / 2, 1'((c / 2) % 2), 'h200 + c / 2, 1'b0);
            else
                chk_cdb($sformatf("strm.c%0d", c), 1'b1, 8 + c / 2,
                        'hB0 + c / 2, 1'b0, 0, 1'b1);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_cdb("rst", 1'b0, 0, 0, 1'b0, 0, 1'b0);
        chk("rst.alu_rdy", 64'(alu_rdy_o), 64'd1);
        chk("rst.lsb_rdy", 64'(lsb_rdy_o), 64'd1);

        // Single ALU push, one-cycle latency, then data holds
        push_alu(3, 'h55, 1'b1, 'h100);
        step();
        chk_cdb("single", 1'b1, 3, 'h55, 1'b1, 'h100, 1'b0);
        idle();
        step();
        chk_cdb("single.idle", 1'b0, 3, 'h55, 1'b1, 'h100, 1'b0);

        // Both streaming: strict alternation
        do_reset();
        stream(12);
        idle();
        step();
        chk("strm.end.en", 64'(cdb_en_o), 64'd0);

        // Flush with 3 entries queued and RR favouring LSB
        do_reset();
        stream(5);
        idle();
        br_flag = 1'b1;
        push_alu(5, 'h5, 1'b0, 0);
        step();
        chk("flush.en", 64'(cdb_en_o), 64'd0);
        chk("flush.q_hold", 64'(cdb_q_o), 64'd2);
        chk("flush.alu_rdy", 64'(alu_rdy_o), 64'd1);
        chk("flush.lsb_rdy", 64'(lsb_rdy_o), 64'd1);
        idle();
        push_alu(7, 'h77, 1'b0, 'h7);
        push_lsb(8, 'h88);
        step();
        chk_cdb("flush.a7", 1'b1, 7, 'h77, 1'b0, 'h7, 1'b0);
        idle();
        step();
        chk_cdb("flush.l8", 1'b1, 8, 'h88, 1'b0, 0, 1'b1);
        step();
        chk("flush.drain", 64'(cdb_en_o), 64'd0);

        // Fill LSB FIFO with q=1,2 while the ALU drains
        do_reset();
        push_alu(9, 'h99, 1'b0, 0);
        push_lsb(0, 'hC0);
        step();
        chk_cdb("fill.c0", 1'b1, 9, 'h99, 1'b0, 0, 1'b0);
        idle();
        push_alu(10, 'h10, 1'b1, 'h20);
        push_lsb(1, 'hC1);
        step();
        chk_cdb("fill.c1", 1'b1, 0, 'hC0, 1'b0, 0, 1'b1);
        idle();
        push_lsb(2, 'hC2);
        step();
        chk_cdb("fill.c2", 1'b1, 10, 'h10, 1'b1, 'h20, 1'b0);
        chk("fill.lsb_full", 64'(lsb_rdy_o), 64'd0);
        idle();
        step();
        chk_cdb("fill.c3", 1'b1, 1, 'hC1, 1'b0, 0, 1'b1);
        chk("fill.lsb_rdy", 64'(lsb_rdy_o), 64'd1);
        step();
        chk_cdb("fill.c4", 1'b1, 2, 'hC2, 1'b0, 0, 1'b1);
        step();
        chk("fill.done", 64'(cdb_en_o), 64'd0);

        // Freeze with a pending LSB entry and noisy inputs
        push_alu(11, 'h11, 1'b0, 0);
        push_lsb(12, 'h12);
        step();
        chk_cdb("frz.pre", 1'b1, 11, 'h11, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            en = 1'b0;
            br_flag = k[0];
            push_alu(13 + k, 'h40 + k, 1'b1, 'h80);
            push_lsb(14, 'h50 + k);
            step();
            chk_cdb($sformatf("frz.k%0d", k), 1'b1, 11, 'h11, 1'b0, 0, 1'b0);
        end
        idle();
        step();
        chk_cdb("frz.resume", 1'b1, 12, 'h12, 1'b0, 0, 1'b1);
        step();
        chk("frz.done", 64'(cdb_en_o), 64'd0);

        // Async reset with two entries queued
        push_alu(1, 'h1, 1'b0, 0);
        push_lsb(2, 'h2);
        step();
        push_alu(3, 'h3, 1'b0, 0);
        push_lsb(4, 'h4);
        step();
        chk_cdb("arst.pre", 1'b1, 2, 'h2, 1'b0, 0, 1'b1);
        idle();
        #3;
        rst = 1'b0;
        #1;
        chk_cdb("arst.low", 1'b0, 0, 0, 1'b0, 0, 1'b0);
        chk("arst.alu_rdy", 64'(alu_rdy_o), 64'd1);
        chk("arst.lsb_rdy", 64'(lsb_rdy_o), 64'd1);
        step();
        rst = 1'b1;
        step();
        chk("arst.post.en", 64'(cdb_en_o), 64'd0);
        chk("arst.post.alu_rdy", 64'(alu_rdy_o), 64'd1);
        chk("arst.post.lsb_rdy", 64'(lsb_rdy_o), 64'd1);
        step();
        chk("arst.post2.en", 64'(cdb_en_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
